// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types and constants for the capture sequencer
package capture_pkg;

  localparam int         SAMPLE_W            = 14;
  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READOUT,
    HOLDOFF
  } capture_state_t;

  typedef enum logic [1:0] {
    PH_HDR,
    PH_HI,
    PH_LO
  } byte_phase_t;

endpackage

// File: rtl/edge_trigger_detect.sv
// rtl/edge_trigger_detect.sv - threshold crossing detector on the live ADC stream
module edge_trigger_detect
  import capture_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] signal,
  input  logic [SAMPLE_W-1:0] threshold,
  input  logic                edge_sel,
  output logic                crossing
);

  logic [SAMPLE_W-1:0] prev_sample_q;
  logic [SAMPLE_W-1:0] prev_sample_d;

  always_comb begin
    prev_sample_d = signal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sample_q <= '0;
    end else begin
      prev_sample_q <= prev_sample_d;
    end
  end

  always_comb begin
    crossing = 1'b0;
    if (edge_sel) begin
      crossing = (prev_sample_q >= threshold) && (signal < threshold);
    end else begin
      crossing = (prev_sample_q < threshold) && (signal >= threshold);
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - arm/trigger/capture/readout sequencer for one waveform record
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int         CAPTURE_LEN    = 500,
  parameter int         HOLDOFF_CYCLES = 1024,
  parameter logic [7:0] HEADER_BYTE    = DEFAULT_HEADER_BYTE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] signal,
  input  logic [SAMPLE_W-1:0] threshold,
  input  logic                edgeSel,
  input  logic                autoRearm,
  input  logic                arm,
  input  logic                forceTrig,
  input  logic                abort,
  output logic                triggerOut,
  output logic [8:0]          rdAddr,
  input  logic [SAMPLE_W-1:0] rdData,
  output logic [7:0]          txData,
  output logic                txValid,
  input  logic                txReady,
  output logic                busy,
  output logic [15:0]         recordCount
);

  localparam int CNT_MAX = (CAPTURE_LEN + 1 > HOLDOFF_CYCLES) ? CAPTURE_LEN + 1 : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(CAPTURE_LEN + 1);
  localparam logic [8:0]       LAST_ADDR = 9'(CAPTURE_LEN - 1);

  capture_state_t   state_q,   state_d;
  byte_phase_t      phase_q,   phase_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [8:0]       rd_addr_q, rd_addr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       lo_byte_q, lo_byte_d;
  logic             tx_valid_q, tx_valid_d;
  logic             trigger_q, trigger_d;
  logic [15:0]      rec_cnt_q, rec_cnt_d;

  logic crossing;
  logic accept;
  logic last_sample;
  logic load_next;

  edge_trigger_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .signal   (signal),
    .threshold(threshold),
    .edge_sel (edgeSel),
    .crossing (crossing)
  );

  assign accept      = tx_valid_q & txReady;
  assign last_sample = (rd_addr_q == LAST_ADDR);
  // Present the next sample's address while its predecessor's low byte is accepted,
  // so the following high byte can be loaded without a gap in txValid.
  assign load_next   = (state_q == READOUT) && accept && (phase_q == PH_LO) && !last_sample;
  assign rdAddr      = load_next ? rd_addr_q + 9'd1 : rd_addr_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    lo_byte_d  = lo_byte_q;
    tx_valid_d = tx_valid_q;
    trigger_d  = 1'b0;
    rec_cnt_d  = rec_cnt_q;

    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (crossing || forceTrig) begin
          state_d   = CAPTURE;
          trigger_d = 1'b1;
          cnt_d     = '0;
        end
      end
      CAPTURE: begin
        if (cnt_q == CAP_LAST) begin
          state_d   = READOUT;
          cnt_d     = '0;
          rd_addr_d = '0;
          phase_d   = PH_HDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READOUT: begin
        // txValid is low in READOUT only on the entry cycle.
        if (!tx_valid_q) begin
          tx_data_d  = HEADER_BYTE;
          tx_valid_d = 1'b1;
          phase_d    = PH_HDR;
        end else if (accept) begin
          case (phase_q)
            PH_HDR: begin
              tx_data_d = {2'b00, rdData[13:8]};
              lo_byte_d = rdData[7:0];
              phase_d   = PH_HI;
            end
            PH_HI: begin
              tx_data_d = lo_byte_q;
              phase_d   = PH_LO;
            end
            default: begin
              if (last_sample) begin
                tx_valid_d = 1'b0;
                rec_cnt_d  = rec_cnt_q + 16'd1;
                state_d    = HOLDOFF;
                cnt_d      = '0;
                rd_addr_d  = '0;
                phase_d    = PH_HDR;
              end else begin
                rd_addr_d = rd_addr_q + 9'd1;
                tx_data_d = {2'b00, rdData[13:8]};
                lo_byte_d = rdData[7:0];
                phase_d   = PH_HI;
              end
            end
          endcase
        end
      end
      HOLDOFF: begin
        if ((int'(cnt_q) + 1) >= HOLDOFF_CYCLES) begin
          state_d = autoRearm ? ARMED : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      phase_d    = PH_HDR;
      cnt_d      = '0;
      rd_addr_d  = '0;
      tx_data_d  = '0;
      lo_byte_d  = '0;
      tx_valid_d = 1'b0;
      trigger_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= PH_HDR;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
      lo_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      trigger_q  <= 1'b0;
      rec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      lo_byte_q  <= lo_byte_d;
      tx_valid_q <= tx_valid_d;
      trigger_q  <= trigger_d;
      rec_cnt_q  <= rec_cnt_d;
    end
  end

  assign triggerOut  = trigger_q;
  assign txData      = tx_data_q;
  assign txValid     = tx_valid_q;
  assign recordCount = rec_cnt_q;
  assign busy        = (state_q != IDLE) && (state_q != ARMED);

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - directed self-checking bench for capture_sequencer
module tb_capture_sequencer;

  localparam int CL = 8;
  localparam int HO = 4;
  localparam int NV = 7;
  localparam int REC_BYTES = 1 + 2 * CL;

  logic        clk, rst;
  logic [13:0] signal, threshold, rdData;
  logic        edgeSel, autoRearm, arm, forceTrig, abort, txReady;
  logic        triggerOut, txValid, busy;
  logic [8:0]  rdAddr;
  logic [7:0]  txData;
  logic [15:0] recordCount;

  logic [13:0] mem [0:CL-1];
  logic [7:0]  got [0:31];
  int          got_n;
  int          errors = 0;
  int          checks = 0;
  int          exp_records = 0;

  typedef struct {
    logic [13:0] sig;
    logic        arm_i;
    logic        ftrig;
    logic        exp_trig;
    logic        exp_busy;
  } vec_t;
  vec_t vecs [NV];

  assign rdData = mem[rdAddr[2:0]];

  capture_sequencer #(
    .CAPTURE_LEN   (CL),
    .HOLDOFF_CYCLES(HO),
    .HEADER_BYTE   (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .signal     (signal),
    .threshold  (threshold),
    .edgeSel    (edgeSel),
    .autoRearm  (autoRearm),
    .arm        (arm),
    .forceTrig  (forceTrig),
    .abort      (abort),
    .triggerOut (triggerOut),
    .rdAddr     (rdAddr),
    .rdData     (rdData),
    .txData     (txData),
    .txValid    (txValid),
    .txReady    (txReady),
    .busy       (busy),
    .recordCount(recordCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [13:0] s;
    if (i == 0) return 8'hA5;
    s = mem[(i - 1) / 2];
    if (i % 2 == 1) return {2'b00, s[13:8]};
    return s[7:0];
  endfunction

  task automatic reset_check(input string tag);
    chk({tag, "_trig"},  triggerOut,  0);
    chk({tag, "_valid"}, txValid,     0);
    chk({tag, "_data"},  txData,      0);
    chk({tag, "_addr"},  rdAddr,      0);
    chk({tag, "_count"}, recordCount, 0);
    chk({tag, "_busy"},  busy,        0);
  endtask

  // ready_mode 0: txReady always high; 1: high one cycle in three.
  task automatic collect(input int max_bytes, input int ready_mode, input bit noise);
    int   acc, cyc, cont_bad, trig_bad;
    bit   started, hold_pend;
    logic [7:0] held;
    acc = 0; cyc = 0; cont_bad = 0; trig_bad = 0;
    started = 0; hold_pend = 0; held = '0;
    while (acc < max_bytes && cyc < 400) begin
      txReady = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (noise) signal = cyc[0] ? 14'd2000 : 14'd0;
      if (hold_pend) chk("hold_stable", {23'd0, txValid, txData}, {23'd0, 1'b1, held});
      if (txValid) started = 1;
      if (started && ready_mode == 0 && !txValid) cont_bad++;
      if (triggerOut) trig_bad++;
      hold_pend = txValid && !txReady;
      held      = txData;
      if (txValid && txReady) begin
        got[acc] = txData;
        acc++;
      end
      tick();
      cyc++;
    end
    got_n   = acc;
    txReady = 1'b0;
    if (noise) signal = 14'd0;
    chk("byte_count", got_n, max_bytes);
    if (ready_mode == 0) chk("valid_continuous", cont_bad, 0);
    if (noise) chk("no_extra_trigger", trig_bad, 0);
  endtask

  task automatic check_record(input string tag);
    for (int i = 0; i < REC_BYTES; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp_byte(i));
    end
    chk({tag, "_count"}, recordCount, exp_records);
    chk({tag, "_valid_low"}, txValid, 0);
    chk({tag, "_holdoff_busy"}, busy, 1);
  endtask

  task automatic arm_and_force;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    forceTrig = 1'b1;
    tick();
    forceTrig = 1'b0;
    chk("force_trigger", triggerOut, 1);
    tick();
  endtask

  initial begin
    rst = 1'b1; signal = '0; threshold = 14'd1000; edgeSel = 1'b0; autoRearm = 1'b0;
    arm = 1'b0; forceTrig = 1'b0; abort = 1'b0; txReady = 1'b0;
    for (int i = 0; i < CL; i++) mem[i] = 14'h3ABC;

    vecs[0] = '{14'd990,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{14'd1000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{14'd990,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{14'd995,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{14'd1000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{14'd1005, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{14'd1010, 1'b0, 1'b0, 1'b0, 1'b1};

    #20;
    reset_check("reset");
    #2 rst = 1'b0;
    tick();

    // Ramp: crossing ignored in IDLE, then exactly one pulse after the 1000 sample.
    for (int v = 0; v < NV; v++) begin
      signal    = vecs[v].sig;
      arm       = vecs[v].arm_i;
      forceTrig = vecs[v].ftrig;
      tick();
      chk($sformatf("vec%0d_trig", v), triggerOut, vecs[v].exp_trig);
      chk($sformatf("vec%0d_busy", v), busy,       vecs[v].exp_busy);
    end
    arm = 1'b0; forceTrig = 1'b0; signal = 14'd0;

    collect(REC_BYTES, 0, 0);
    exp_records = 1;
    check_record("rec1");

    repeat (6) tick();
    forceTrig = 1'b1;
    tick();
    forceTrig = 1'b0;
    chk("idle_ignores_force", triggerOut, 0);

    // Throttled receiver.
    arm_and_force();
    collect(REC_BYTES, 1, 0);
    exp_records = 2;
    check_record("rec2");

    // Abort after the fifth accepted byte.
    repeat (6) tick();
    arm_and_force();
    collect(5, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy",  busy,        0);
    chk("abort_valid", txValid,     0);
    chk("abort_addr",  rdAddr,      0);
    chk("abort_count", recordCount, exp_records);
    forceTrig = 1'b1;
    tick();
    forceTrig = 1'b0;
    chk("abort_is_idle", triggerOut, 0);
    for (int i = 0; i < CL; i++) mem[i] = 14'(i * 1371 + 77);
    arm_and_force();
    collect(REC_BYTES, 0, 0);
    exp_records = 3;
    check_record("rec3");

    // Auto re-arm after a four-cycle holdoff.
    repeat (6) tick();
    autoRearm = 1'b1;
    arm_and_force();
    collect(REC_BYTES, 0, 0);
    exp_records = 4;
    check_record("rec4");
    for (int i = 1; i < HO; i++) begin
      tick();
      chk($sformatf("holdoff_cycle%0d", i + 1), busy, 1);
    end
    tick();
    chk("rearmed_not_busy", busy, 0);
    forceTrig = 1'b1;
    tick();
    forceTrig = 1'b0;
    chk("rearmed_trigger", triggerOut, 1);
    tick();
    collect(REC_BYTES, 0, 1);
    exp_records = 5;
    check_record("rec5");

    // Asynchronous reset with a trigger pulse in flight (CAPTURE).
    repeat (6) tick();
    forceTrig = 1'b1;
    tick();
    forceTrig = 1'b0;
    chk("pre_reset_trigger", triggerOut, 1);
    #3 rst = 1'b1;
    #1 reset_check("rst_capture");
    #3 rst = 1'b0;
    exp_records = 0;
    tick();

    // Asynchronous reset mid-READOUT.
    autoRearm = 1'b0;
    arm_and_force();
    collect(2, 0, 0);
    chk("pre_reset_valid", txValid, 1);
    #3 rst = 1'b1;
    #1 reset_check("rst_readout");
    #3 rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Sequences one waveform acquisition from arm to transmit.
- Detects a threshold crossing on the live 14-bit ADC stream.
- Issues a single-cycle trigger pulse to the waveform capture buffer and waits for the buffer to fill.
- Streams the captured record out as bytes to the UART transmitter.
- Sits between the ADC sample bus, the capture buffer and the UART TX byte interface; controlled by arm/abort pulses decoded from UART RX.

Parameters:
CAPTURE_LEN, 500, samples per record; must match the capture buffer depth.
HOLDOFF_CYCLES, 1024, idle cycles after readout before re-arming.
HEADER_BYTE, 8'hA5, first byte of every transmitted record.

Ports:
clk  in  1  system clock, shared with the ADC sample bus.
rst  in  1  reset; asynchronous, active-high.
signal  in  14  live ADC sample, one per clk.
threshold  in  14  trigger level, unsigned.
edgeSel  in  1  0 = rising crossing, 1 = falling crossing.
autoRearm  in  1  1 = return to ARMED after holdoff; 0 = return to IDLE.
arm  in  1  one-cycle arm request.
forceTrig  in  1  software trigger; honoured only in ARMED.
abort  in  1  one-cycle abort request.
triggerOut  out  1  one-cycle pulse to the capture buffer's trigger input.
rdAddr  out  9  capture buffer read index (0..CAPTURE_LEN-1).
rdData  in  14  capture buffer word at rdAddr; combinational, valid in the same cycle.
txData  out  8  byte to the UART transmitter.
txValid  out  1  txData valid.
txReady  in  1  UART accepts the byte when txValid and txReady are both high.
busy  out  1  high in every state except IDLE and ARMED.
recordCount  out  16  records fully transmitted; wraps 65535 -> 0.

Behaviour:
- Reset values: state = IDLE; triggerOut = 0; txValid = 0; txData = 0; rdAddr = 0; recordCount = 0; prevSample = 0; all counters = 0.
- Crossing detect uses prevSample, registered every cycle in every state.
  - Rising: prevSample < threshold AND signal >= threshold.
  - Falling: prevSample >= threshold AND signal < threshold.
  - Comparisons are unsigned, 14-bit.
- States: IDLE, ARMED, CAPTURE, READOUT, HOLDOFF.
- IDLE: arm -> ARMED on the next cycle.
- ARMED: a crossing or forceTrig moves to CAPTURE.
  - triggerOut is high for exactly that transition cycle, registered, so it is visible the cycle after the crossing sample.
  - A crossing in the first ARMED cycle counts, using the prevSample already held.
- CAPTURE: wait counter runs 0..CAPTURE_LEN+1, then -> READOUT with rdAddr = 0.
  - Total CAPTURE dwell is CAPTURE_LEN+2 cycles, covering the buffer write latency.
  - Crossings, arm and forceTrig are ignored.
- READOUT: byte sequence is HEADER_BYTE, then for each addr 0..CAPTURE_LEN-1:
  - {2'b00, rdData[13:8]}, then rdData[7:0].
  - Total bytes per record = 1 + 2*CAPTURE_LEN.
  - Sample data is latched when its high byte is loaded, so rdData may change while the low byte is pending.
- TX handshake:
  - txValid rises with the first byte loaded.
  - txData and txValid hold steady until a cycle with txValid & txReady.
  - The next byte is loaded in the cycle after acceptance, so txValid stays high continuously when txReady is held high.
  - No combinational path from txReady to txValid.
  - rdAddr increments after the low byte of a sample is accepted.
- End of readout: after the last byte is accepted, txValid = 0, recordCount increments, and the state moves to HOLDOFF.
- HOLDOFF: counts HOLDOFF_CYCLES cycles, then -> ARMED if autoRearm, else IDLE.
  - autoRearm is sampled on the exit cycle.
  - HOLDOFF_CYCLES = 0 exits on the first HOLDOFF cycle.
- abort: from any state, next state = IDLE; txValid = 0 next cycle; counters and rdAddr cleared.
  - A partial record is not counted in recordCount.
  - If abort and arm coincide, abort wins.
- arm outside IDLE is ignored.
- Reset asserted mid-operation: immediate return to the reset values above, including in-flight triggerOut and txValid.

Decomposition:
- Package capture_pkg:
  - state enum capture_state_t {IDLE, ARMED, CAPTURE, READOUT, HOLDOFF}
  - SAMPLE_W = 14
  - default HEADER_BYTE
  - byte-phase enum {PH_HDR, PH_HI, PH_LO}
- Sub-module edge_trigger_detect: registers prevSample; outputs a combinational crossing flag from signal, threshold and edgeSel.
- The FSM, TX byte serializer and counters stay in capture_sequencer.

Test Plan:
- CAPTURE_LEN=8, threshold=1000, edgeSel=0, arm; ramp 990..1010 in steps of 5 -> one triggerOut pulse, the cycle after the sample reaching 1000; none in IDLE before arm.
- Same setup, txReady held high, buffer preloaded with 0x3ABC at every addr -> 17 bytes: A5, then 3A, BC repeated 8 times; txValid continuous; recordCount = 1.
- txReady toggled 1-of-3 cycles -> identical byte sequence; txData stable whenever txValid && !txReady.
- abort asserted after the 5th byte is accepted -> IDLE next cycle; txValid = 0; recordCount unchanged; a later arm+trigger sends a full 17-byte record.
- autoRearm=1, HOLDOFF_CYCLES=4, forceTrig pulsed -> ARMED exactly 4 cycles after the last byte; a second forceTrig gives recordCount = 2; a crossing during CAPTURE/READOUT produces no extra triggerOut.
- Reset asserted in CAPTURE and in READOUT -> all outputs at reset values in the same cycle, asynchronously; recordCount = 0.
